fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 CLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset; RESET=0 SHALL reset the block immediately, regardless of CLK.
REQ-004 FETCH_EN  in  1  1 = fetching permitted; 0 = issue no new memory requests.
REQ-005 MEM_REQ  out  1  instruction-memory request.
REQ-006 MEM_ADDR  out  64  byte address of the request (PC).
REQ-007 MEM_ACK  in  1  memory completes the request this cycle.
REQ-008 MEM_INST  in  32  instruction word, valid when MEM_ACK=1.
REQ-009 REDIRECT  in  1  branch/jump redirect strobe.
REQ-010 REDIRECT_PC  in  64  redirect target; bits [1:0] SHALL be ignored and treated as 00.
REQ-011 IF_VALID  out  1  IF_INST/IF_PC hold a fetched instruction.
REQ-012 IF_READY  in  1  decode accepts the instruction (handshake when IF_VALID&IF_READY).
REQ-013 IF_INST  out  32  head-of-buffer instruction.
REQ-014 IF_PC  out  64  address of IF_INST.

Function
REQ-015 The block SHALL hold PC (64 b), a 2-entry FIFO of {PC,INST}, count 0..2, and FSM {IDLE, FETCH, HOLD, DRAIN}.
REQ-016 MEM_REQ SHALL be 1 exactly in FETCH and DRAIN; MEM_ADDR SHALL equal PC in FETCH and stay constant while MEM_REQ=1 without MEM_ACK.
REQ-017 At most one request SHALL be outstanding; MEM_ACK in the same cycle as MEM_REQ rises (zero latency) SHALL be legal; MEM_ACK while MEM_REQ=0 SHALL be ignored.
REQ-018 IDLE SHALL last exactly one cycle after reset release, then go to FETCH if FETCH_EN=1, else HOLD.
REQ-019 FETCH + MEM_ACK (no REDIRECT): push {PC,MEM_INST}, PC <= PC+4 (mod 2^64 wrap); stay FETCH if FETCH_EN=1 and count_next<2, else HOLD.
REQ-020 HOLD SHALL go to FETCH the cycle after FETCH_EN=1 and count_next<2.
REQ-021 count_next = count + push - pop; pop = IF_VALID&IF_READY; simultaneous push and pop SHALL leave count unchanged; push SHALL never occur at count=2.
REQ-022 IF_VALID = (count!=0); IF_INST/IF_PC SHALL be the oldest entry; with MEM_ACK tied 1 and IF_READY=1, throughput SHALL be one instruction per cycle.
REQ-023 Fetch-to-decode latency SHALL be one cycle: an entry pushed in cycle N is presented with IF_VALID=1 in cycle N+1.
REQ-024 REDIRECT (any state): FIFO flushed (count<=0), PC <= {REDIRECT_PC[63:2],2'b00}; a pop in the same cycle SHALL be discarded; IF_VALID SHALL be 0 the next cycle.
REQ-025 REDIRECT in FETCH with MEM_ACK=1: returned word discarded, next state FETCH (or HOLD if FETCH_EN=0).
REQ-026 REDIRECT in FETCH with MEM_ACK=0: next state DRAIN; DRAIN SHALL keep MEM_REQ=1 and the old MEM_ADDR until MEM_ACK, discard that word, then enter FETCH (or HOLD if FETCH_EN=0).
REQ-027 REDIRECT during DRAIN SHALL update PC only; REDIRECT in IDLE/HOLD SHALL update PC and flush.
REQ-028 FETCH_EN falling with a request outstanding SHALL NOT abort it; transition to HOLD follows its MEM_ACK.

Reset
REQ-029 While RESET=0: state=IDLE, PC=RESET_PC, count=0, MEM_REQ=0, MEM_ADDR=RESET_PC, IF_VALID=0, IF_INST=0, IF_PC=0.
REQ-030 RESET asserted mid-request SHALL abandon the request; a MEM_ACK arriving after release while in IDLE SHALL be ignored.

Structure
REQ-031 State encoding, XLEN=64, ILEN=32 and PC increment 4 SHALL live in shared package rv64_pkg.
REQ-032 The 2-entry FIFO SHALL be sub-module fetch_buf (push/pop/flush, count, head data).

Verification
REQ-033 Reset release, FETCH_EN=1, MEM_ACK=1, IF_READY=1 -> MEM_ADDR 0,4,8,12 on consecutive cycles; IF_PC 0,4,8 from second cycle.
REQ-034 IF_READY=0, MEM_ACK=1 -> two pushes (PC 0,4), then HOLD, MEM_REQ=0, IF_PC stays 0; IF_READY=1 -> fetching resumes at 8.
REQ-035 MEM_ACK delayed 3 cycles -> MEM_ADDR stable at 0x10 for all 4 cycles; exactly one push.
REQ-036 REDIRECT_PC=0x103 while request to 0x20 outstanding -> DRAIN, 0x20 data discarded, next MEM_ADDR=0x100, IF_VALID=0 until 0x100 returns.
REQ-037 REDIRECT with MEM_ACK same cycle, plus RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> word discarded; wrap: address after ..FFFC is 0.
REQ-038 RESET=0 asynchronously mid-DRAIN -> all outputs at reset values before next CLK edge.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared RV64 fetch definitions: machine widths, PC step and fetch FSM states.
package rv64_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry {PC, instruction} FIFO between fetch and decode, with flush.
module fetch_buf
  import rv64_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] push_pc_i,
  input  logic [ILEN-1:0] push_inst_i,
  output logic [1:0]      count_o,
  output logic [XLEN-1:0] head_pc_o,
  output logic [ILEN-1:0] head_inst_o
);

  logic [XLEN-1:0] pc_q   [2];
  logic [ILEN-1:0] inst_q [2];
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            wr_ptr;

  // Write slot is the one after the head when a single entry is held.
  assign wr_ptr = rd_ptr_q ^ count_q[0];

  // Occupancy and read pointer; flush empties the buffer outright.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
      rd_ptr_d = rd_ptr_q ^ pop_i;
    end
  end

  // Pointer/count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else if (push_i && !flush_i) begin
      pc_q[wr_ptr]   <= push_pc_i;
      inst_q[wr_ptr] <= push_inst_i;
    end
  end

  assign count_o     = count_q;
  assign head_pc_o   = pc_q[rd_ptr_q];
  assign head_inst_o = inst_q[rd_ptr_q];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding memory requests, redirect
// with drain of an in-flight request, and a 2-entry buffer toward decode.
module fetch_ctrl
  import rv64_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            FETCH_EN,
  output logic            MEM_REQ,
  output logic [XLEN-1:0] MEM_ADDR,
  input  logic            MEM_ACK,
  input  logic [ILEN-1:0] MEM_INST,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IF_VALID,
  input  logic            IF_READY,
  output logic [ILEN-1:0] IF_INST,
  output logic [XLEN-1:0] IF_PC
);

  localparam logic [XLEN-1:0] PC_RST = RESET_PC & ~64'd3;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [XLEN-1:0] redirect_tgt;
  logic            push, pop, flush;
  logic [1:0]      count, count_next;

  assign redirect_tgt = REDIRECT_PC & ~64'd3;
  // A redirect discards any handshake in the same cycle.
  assign pop        = IF_VALID & IF_READY & ~REDIRECT;
  assign count_next = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};

  // Buffer push/flush and PC updates for the current state.
  always_comb begin
    push         = 1'b0;
    flush        = 1'b0;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (REDIRECT) begin
          flush = 1'b1;
          pc_d  = redirect_tgt;
        end
      end
      ST_FETCH: begin
        if (REDIRECT) begin
          flush = 1'b1;
          pc_d  = redirect_tgt;
          // PC moves to the target immediately, so the in-flight
          // address is parked for the drain phase.
          if (!MEM_ACK) drain_addr_d = pc_q;
        end else if (MEM_ACK) begin
          push = 1'b1;
          pc_d = pc_q + PC_INC;
        end
      end
      ST_DRAIN: begin
        if (REDIRECT) pc_d = redirect_tgt;
      end
      default: ;
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = FETCH_EN ? ST_FETCH : ST_HOLD;
      ST_FETCH: begin
        if (REDIRECT) begin
          if (MEM_ACK) state_d = FETCH_EN ? ST_FETCH : ST_HOLD;
          else         state_d = ST_DRAIN;
        end else if (MEM_ACK) begin
          state_d = (FETCH_EN && count_next < 2'd2) ? ST_FETCH : ST_HOLD;
        end
      end
      ST_HOLD:  state_d = (FETCH_EN && count_next < 2'd2) ? ST_FETCH : ST_HOLD;
      ST_DRAIN: if (MEM_ACK) state_d = FETCH_EN ? ST_FETCH : ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, PC and parked drain address.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      pc_q         <= PC_RST;
      drain_addr_q <= PC_RST;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_buf u_buf (
    .clk_i       (CLK),
    .rst_ni      (RESET),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_pc_i   (pc_q),
    .push_inst_i (MEM_INST),
    .count_o     (count),
    .head_pc_o   (IF_PC),
    .head_inst_o (IF_INST)
  );

  assign MEM_REQ  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign MEM_ADDR = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign IF_VALID = (count != 2'd0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_ctrl;

  logic        CLK, RESET;
  logic        FETCH_EN, MEM_ACK, REDIRECT, IF_READY;
  logic [31:0] MEM_INST;
  logic [63:0] REDIRECT_PC;
  logic        MEM_REQ, IF_VALID;
  logic [63:0] MEM_ADDR, IF_PC;
  logic [31:0] IF_INST;

  logic        w_en, w_ack, w_redir, w_rdy;
  logic [31:0] w_inst;
  logic [63:0] w_rpc;
  logic        w_req, w_valid;
  logic [63:0] w_addr, w_ifpc;
  logic [31:0] w_ifinst;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  fetch_ctrl u_dut (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(FETCH_EN), .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_INST(MEM_INST),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC), .IF_VALID(IF_VALID),
    .IF_READY(IF_READY), .IF_INST(IF_INST), .IF_PC(IF_PC)
  );

  fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .CLK(CLK), .RESET(RESET), .FETCH_EN(w_en), .MEM_REQ(w_req),
    .MEM_ADDR(w_addr), .MEM_ACK(w_ack), .MEM_INST(w_inst),
    .REDIRECT(w_redir), .REDIRECT_PC(w_rpc), .IF_VALID(w_valid),
    .IF_READY(w_rdy), .IF_INST(w_ifinst), .IF_PC(w_ifpc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: a queue of fetched entries plus request status flags.
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          m_boot, m_req_on, m_discard;
  logic [63:0] m_pc, m_drain_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_boot = 1; m_req_on = 0; m_discard = 0;
    m_pc = 64'h0; m_drain_addr = 64'h0;
  endtask

  task automatic model_update(input bit en, ack, rdy, rd,
                              input logic [63:0] rpc, input logic [31:0] inst);
    logic [63:0] tgt;
    bit pop;
    tgt = {rpc[63:2], 2'b00};
    pop = (mq.size() != 0) && rdy && !rd;
    if (m_boot) begin
      m_boot = 0;
      if (rd) begin mq.delete(); m_pc = tgt; end
      m_req_on = en;
    end else if (m_discard) begin
      if (rd) m_pc = tgt;
      if (ack) begin m_discard = 0; m_req_on = en; end
    end else if (m_req_on) begin
      if (rd) begin
        mq.delete();
        if (ack) m_req_on = en;
        else begin m_discard = 1; m_req_on = 0; m_drain_addr = m_pc; end
        m_pc = tgt;
      end else begin
        if (pop) void'(mq.pop_front());
        if (ack) begin
          mq.push_back('{m_pc, inst});
          m_pc = m_pc + 64'd4;
          m_req_on = en && (mq.size() < 2);
        end
      end
    end else begin
      if (rd) begin mq.delete(); m_pc = tgt; end
      else if (pop) void'(mq.pop_front());
      m_req_on = en && (mq.size() < 2);
    end
  endtask

  task automatic compare_all();
    chk("mem_req",  MEM_REQ,  m_req_on || m_discard);
    chk("mem_addr", MEM_ADDR, m_discard ? m_drain_addr : m_pc);
    chk("if_valid", IF_VALID, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("if_pc",   IF_PC,   mq[0].pc);
      chk("if_inst", IF_INST, mq[0].inst);
    end
  endtask

  task automatic step(input bit en, ack, rdy, rd, input logic [63:0] rpc);
    logic [31:0] inst;
    inst = $urandom;
    FETCH_EN = en; MEM_ACK = ack; IF_READY = rdy; REDIRECT = rd;
    REDIRECT_PC = rpc; MEM_INST = inst;
    @(posedge CLK);
    model_update(en, ack, rdy, rd, rpc, inst);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic reset_main();
    RESET = 1'b0;
    @(negedge CLK);
    model_reset();
    RESET = 1'b1;
  endtask

  initial begin
    RESET = 1'b0;
    FETCH_EN = 0; MEM_ACK = 0; REDIRECT = 0; IF_READY = 0;
    MEM_INST = '0; REDIRECT_PC = '0;
    w_en = 0; w_ack = 0; w_redir = 0; w_rdy = 0; w_inst = '0; w_rpc = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_req",   MEM_REQ,  0);
    chk("rst_addr",  MEM_ADDR, 0);
    chk("rst_valid", IF_VALID, 0);
    chk("rst_inst",  IF_INST,  0);
    chk("rst_pc",    IF_PC,    0);
    RESET = 1'b1;

    // Streaming at one instruction per cycle.
    step(1, 1, 1, 0, 0); chk("s_addr0", MEM_ADDR, 64'd0);
    step(1, 1, 1, 0, 0); chk("s_addr4", MEM_ADDR, 64'd4);  chk("s_ifpc0", IF_PC, 64'd0);
    step(1, 1, 1, 0, 0); chk("s_addr8", MEM_ADDR, 64'd8);  chk("s_ifpc4", IF_PC, 64'd4);
    step(1, 1, 1, 0, 0); chk("s_addr12", MEM_ADDR, 64'd12); chk("s_ifpc8", IF_PC, 64'd8);

    // Decode stalled: buffer fills, fetch holds, then resumes at 8.
    reset_main();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0); chk("f_req_hold", MEM_REQ, 0); chk("f_ifpc0", IF_PC, 64'd0);
    step(1, 1, 0, 0, 0); chk("f_req_hold2", MEM_REQ, 0); chk("f_ifpc0b", IF_PC, 64'd0);
    step(1, 1, 1, 0, 0); chk("f_resume_req", MEM_REQ, 1); chk("f_resume_addr", MEM_ADDR, 64'd8);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0); chk("d_addr10", MEM_ADDR, 64'h10);

    // Memory stalls three cycles on address 0x10.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, 0); chk("d_addr_stable", MEM_ADDR, 64'h10);
    end
    step(1, 1, 1, 0, 0); chk("d_push_pc", IF_PC, 64'h10); chk("d_push_valid", IF_VALID, 1);
    step(1, 0, 1, 0, 0); chk("d_one_push", IF_VALID, 0);

    // Redirect while the request to 0x20 is outstanding.
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0); chk("r_addr20", MEM_ADDR, 64'h20);
    step(1, 0, 1, 1, 64'h103); chk("r_drain_addr", MEM_ADDR, 64'h20); chk("r_drain_valid", IF_VALID, 0);
    step(1, 0, 1, 0, 0); chk("r_drain_hold", MEM_ADDR, 64'h20);
    step(1, 1, 1, 0, 0); chk("r_new_addr", MEM_ADDR, 64'h100); chk("r_new_valid", IF_VALID, 0);
    step(1, 1, 1, 0, 0); chk("r_new_pc", IF_PC, 64'h100); chk("r_new_valid1", IF_VALID, 1);

    // Asynchronous reset mid-drain.
    step(1, 0, 1, 1, 64'h200); chk("a_in_drain", MEM_ADDR, 64'h104);
    #2 RESET = 1'b0;
    #1;
    chk("a_req",   MEM_REQ,  0);
    chk("a_addr",  MEM_ADDR, 0);
    chk("a_valid", IF_VALID, 0);
    chk("a_inst",  IF_INST,  0);
    chk("a_pc",    IF_PC,    0);
    model_reset();
    @(negedge CLK);
    RESET = 1'b1;
    // Late ack while idle must be ignored.
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0); chk("a_late_ack", IF_VALID, 0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 8) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
           ($urandom % 16) == 0, {$urandom, $urandom});
    end

    // Wrap instance: fetch at ..FFFC, wrap to 0, redirect with ack discards.
    FETCH_EN = 0; MEM_ACK = 0; REDIRECT = 0;
    RESET = 1'b0;
    #1;
    chk("w_rst_addr", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_rst_req",  w_req,  0);
    @(negedge CLK);
    RESET = 1'b1;
    w_en = 1; w_ack = 1; w_rdy = 1; w_inst = 32'hAAAA_0001;
    @(posedge CLK); @(negedge CLK);
    chk("w_addr_top", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_req_on",   w_req,  1);
    w_inst = 32'hBBBB_0002;
    @(posedge CLK); @(negedge CLK);
    chk("w_wrap_addr", w_addr,   64'h0);
    chk("w_wrap_pc",   w_ifpc,   64'hFFFF_FFFF_FFFF_FFFC);
    chk("w_wrap_inst", w_ifinst, 32'hBBBB_0002);
    w_redir = 1; w_rpc = 64'h41; w_inst = 32'hCCCC_0003;
    @(posedge CLK); @(negedge CLK);
    chk("w_rd_valid", w_valid, 0);
    chk("w_rd_addr",  w_addr,  64'h40);
    chk("w_rd_req",   w_req,   1);
    w_redir = 0; w_inst = 32'hDDDD_0004;
    @(posedge CLK); @(negedge CLK);
    chk("w_tgt_valid", w_valid,  1);
    chk("w_tgt_pc",    w_ifpc,   64'h40);
    chk("w_tgt_inst",  w_ifinst, 32'hDDDD_0004);
    chk("w_tgt_addr",  w_addr,   64'h44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
